// File: rtl/cpu6502_pkg.sv
// Shared types and constants for the 6502 interrupt/reset sequencer.
// State encoding, vector addresses and data-bus push source codes.
package cpu6502_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } seq_state_t;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RES = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  localparam logic [1:0] PUSH_NONE = 2'd0;
  localparam logic [1:0] PUSH_PCH  = 2'd1;
  localparam logic [1:0] PUSH_PCL  = 2'd2;
  localparam logic [1:0] PUSH_P    = 2'd3;

  function automatic logic [7:0] vec_lo(
    input logic [15:0] v
  );
    return v[7:0];
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin, with a
// one-cycle pulse on each falling edge of the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign fall  = s3 & ~s2;

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: pushes PC and P, then
// fetches the selected vector while overriding the decoder.
module interrupt_sequencer
  import cpu6502_pkg::*;
(
  input  logic       phi2,
  input  logic       RES_n,
  input  logic       NMI_n,
  input  logic       IRQ_n,
  input  logic       I_flag,
  input  logic       fetch_T0,
  input  logic       brk_op,
  output logic       seq_active,
  output logic [2:0] seq_state,
  output logic [1:0] push_sel,
  output logic       SP_dec,
  output logic       R_W_n,
  output logic [7:0] vec_ADL,
  output logic [7:0] vec_ADH,
  output logic       DL_PCL,
  output logic       DL_PCH,
  output logic       set_I,
  output logic       B_flag
);

  seq_state_t state;
  seq_state_t next;

  logic       nmi_lvl;
  logic       nmi_fall;
  logic       irq_lvl;
  logic       irq_fall;
  logic       reset_pend;
  logic       nmi_pend;
  logic       is_res;
  logic       is_nmi;
  logic       is_brk;
  logic       pch_q;
  logic [7:0] vec_q;
  logic       irq_take;
  logic       take;
  logic       hijack;

  sync_edge_det u_nmi (
    .clk   (phi2),
    .rst_n (RES_n),
    .din   (NMI_n),
    .level (nmi_lvl),
    .fall  (nmi_fall)
  );

  sync_edge_det u_irq (
    .clk   (phi2),
    .rst_n (RES_n),
    .din   (IRQ_n),
    .level (irq_lvl),
    .fall  (irq_fall)
  );

  assign irq_take = ~irq_lvl & ~I_flag;
  assign take = (state == S_IDLE) & fetch_T0
              & (reset_pend | nmi_pend | irq_take | brk_op);

  // A pending NMI steals an IRQ/BRK vector up to the last push
  assign hijack = (state inside {S_T1, S_T2, S_T3, S_T4})
                & nmi_pend & ~is_res & ~is_nmi;

  always_ff @(posedge phi2 or negedge RES_n) begin
    if (!RES_n) begin
      state      <= S_IDLE;
      reset_pend <= 1'b1;
      nmi_pend   <= 1'b0;
      is_res     <= 1'b0;
      is_nmi     <= 1'b0;
      is_brk     <= 1'b0;
      pch_q      <= 1'b0;
      vec_q      <= 8'h00;
    end else begin
      state <= next;
      pch_q <= (state == S_T6);
      if (nmi_fall)
        nmi_pend <= 1'b1;
      else if (state == S_T5 && is_nmi)
        nmi_pend <= 1'b0;
      if (take) begin
        is_res <= 1'b0;
        is_nmi <= 1'b0;
        is_brk <= 1'b0;
        priority case (1'b1)
          reset_pend: begin
            vec_q      <= vec_lo(VEC_RES);
            is_res     <= 1'b1;
            reset_pend <= 1'b0;
          end
          nmi_pend: begin
            vec_q  <= vec_lo(VEC_NMI);
            is_nmi <= 1'b1;
          end
          irq_take: vec_q <= vec_lo(VEC_IRQ);
          default: begin
            vec_q  <= vec_lo(VEC_IRQ);
            is_brk <= 1'b1;
          end
        endcase
      end else if (hijack) begin
        vec_q  <= vec_lo(VEC_NMI);
        is_nmi <= 1'b1;
      end
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  if (take) next = S_T1;
      S_T1:    next = S_T2;
      S_T2:    next = S_T3;
      S_T3:    next = S_T4;
      S_T4:    next = S_T5;
      S_T5:    next = S_T6;
      S_T6:    next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    seq_active = (state != S_IDLE);
    seq_state  = state;
    push_sel   = PUSH_NONE;
    SP_dec     = 1'b0;
    R_W_n      = 1'b1;
    vec_ADL    = 8'h00;
    vec_ADH    = 8'h00;
    DL_PCL     = 1'b0;
    DL_PCH     = pch_q;
    set_I      = 1'b0;
    B_flag     = is_brk & (state != S_IDLE);
    unique case (state)
      S_T2: begin
        push_sel = PUSH_PCH;
        SP_dec   = 1'b1;
        R_W_n    = is_res;
      end
      S_T3: begin
        push_sel = PUSH_PCL;
        SP_dec   = 1'b1;
        R_W_n    = is_res;
      end
      S_T4: begin
        push_sel = PUSH_P;
        SP_dec   = 1'b1;
        R_W_n    = is_res;
      end
      S_T5: begin
        vec_ADL = vec_q;
        vec_ADH = VEC_IRQ[15:8];
        set_I   = 1'b1;
      end
      S_T6: begin
        vec_ADL = vec_q + 8'd1;
        vec_ADH = VEC_IRQ[15:8];
        DL_PCL  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: vector table plus
// hand sequences for hijack, simultaneous sources and reset abort.
module tb_interrupt_sequencer;

  logic       phi2;
  logic       RES_n;
  logic       NMI_n;
  logic       IRQ_n;
  logic       I_flag;
  logic       fetch_T0;
  logic       brk_op;
  logic       seq_active;
  logic [2:0] seq_state;
  logic [1:0] push_sel;
  logic       SP_dec;
  logic       R_W_n;
  logic [7:0] vec_ADL;
  logic [7:0] vec_ADH;
  logic       DL_PCL;
  logic       DL_PCH;
  logic       set_I;
  logic       B_flag;

  int checks;
  int failures;

  interrupt_sequencer dut (
    .phi2       (phi2),
    .RES_n      (RES_n),
    .NMI_n      (NMI_n),
    .IRQ_n      (IRQ_n),
    .I_flag     (I_flag),
    .fetch_T0   (fetch_T0),
    .brk_op     (brk_op),
    .seq_active (seq_active),
    .seq_state  (seq_state),
    .push_sel   (push_sel),
    .SP_dec     (SP_dec),
    .R_W_n      (R_W_n),
    .vec_ADL    (vec_ADL),
    .vec_ADH    (vec_ADH),
    .DL_PCL     (DL_PCL),
    .DL_PCH     (DL_PCH),
    .set_I      (set_I),
    .B_flag     (B_flag)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  typedef struct {
    logic        f;
    logic        br;
    logic        irq;
    logic        nmi;
    logic        ifl;
    logic [27:0] e;
  } row_t;

  row_t tbl[$];

  // {act,state,push,sp,rw,adl,adh,pcl,pch,setI,B}
  function automatic logic [27:0] ex(
    input logic       act,
    input logic [2:0] st,
    input logic [1:0] ps,
    input logic       sp,
    input logic       rw,
    input logic [7:0] adl,
    input logic [7:0] adh,
    input logic       pcl,
    input logic       pch,
    input logic       si,
    input logic       b
  );
    return {act, st, ps, sp, rw, adl, adh, pcl, pch, si, b};
  endfunction

  function automatic row_t mk(
    input logic f, br, irq, nmi, ifl,
    input logic [27:0] e
  );
    row_t r;
    r.f = f; r.br = br; r.irq = irq; r.nmi = nmi; r.ifl = ifl;
    r.e = e;
    return r;
  endfunction

  task automatic check(input string nm, input logic [27:0] e);
    logic [27:0] got;
    got = {seq_active, seq_state, push_sel, SP_dec, R_W_n,
           vec_ADL, vec_ADH, DL_PCL, DL_PCH, set_I, B_flag};
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, e);
    end
  endtask

  task automatic step(
    input logic f, br, irq, nmi, ifl,
    input logic [27:0] e,
    input string nm
  );
    fetch_T0 = f; brk_op = br; IRQ_n = irq; NMI_n = nmi;
    I_flag = ifl;
    @(posedge phi2);
    #1;
    check(nm, e);
  endtask

  logic [27:0] idle0;
  logic [27:0] idle_pch;

  initial begin
    checks   = 0;
    failures = 0;
    idle0    = ex(0,0,0,0,1,8'h00,8'h00,0,0,0,0);
    idle_pch = ex(0,0,0,0,1,8'h00,8'h00,0,1,0,0);
    RES_n = 1'b0; NMI_n = 1'b1; IRQ_n = 1'b1; I_flag = 1'b1;
    fetch_T0 = 1'b0; brk_op = 1'b0;

    // reset sequence
    tbl.push_back(mk(1,0,1,1,1, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,1,1,1, ex(1,2,1,1,1,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,1,1,1, ex(1,3,2,1,1,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,1,1,1, ex(1,4,3,1,1,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,1,1,1, ex(1,5,0,0,1,8'hFC,8'hFF,0,0,1,0)));
    tbl.push_back(mk(0,0,1,1,1, ex(1,6,0,0,1,8'hFD,8'hFF,1,0,0,0)));
    tbl.push_back(mk(0,0,1,1,1, idle_pch));
    tbl.push_back(mk(1,0,1,1,1, idle0));
    // IRQ accepted with I clear
    tbl.push_back(mk(0,0,0,1,0, idle0));
    tbl.push_back(mk(0,0,0,1,0, idle0));
    tbl.push_back(mk(1,0,0,1,0, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(1,4,3,1,0,8'h00,8'h00,0,0,0,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(1,5,0,0,1,8'hFE,8'hFF,0,0,1,0)));
    tbl.push_back(mk(0,0,0,1,0, ex(1,6,0,0,1,8'hFF,8'hFF,1,0,0,0)));
    tbl.push_back(mk(0,0,0,1,1, idle_pch));

    repeat (3) @(posedge phi2);
    #1;
    check("reset_state", idle0);
    RES_n = 1'b1;

    foreach (tbl[i])
      step(tbl[i].f, tbl[i].br, tbl[i].irq, tbl[i].nmi,
           tbl[i].ifl, tbl[i].e, $sformatf("tbl%0d", i));

    // masked IRQ never starts a sequence
    for (int k = 0; k < 10; k++)
      step(1,0,0,1,1, idle0, $sformatf("irq_masked%0d", k));

    // plain BRK
    step(1,1,0,1,1, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,1), "brk_t1");
    step(0,0,0,1,1, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,1), "brk_t2");
    step(0,0,0,1,1, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,1), "brk_t3");
    step(0,0,0,1,1, ex(1,4,3,1,0,8'h00,8'h00,0,0,0,1), "brk_t4");
    step(0,0,0,1,1, ex(1,5,0,0,1,8'hFE,8'hFF,0,0,1,1), "brk_t5");
    step(0,0,0,1,1, ex(1,6,0,0,1,8'hFF,8'hFF,1,0,0,1), "brk_t6");
    step(0,0,0,1,1, idle_pch, "brk_end");

    // NMI falls during BRK: vector hijacked, B kept
    step(1,1,0,1,1, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,1), "hij_t1");
    step(0,0,0,0,1, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,1), "hij_t2");
    step(0,0,0,0,1, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,1), "hij_t3");
    step(0,0,0,0,1, ex(1,4,3,1,0,8'h00,8'h00,0,0,0,1), "hij_t4");
    step(0,0,0,0,1, ex(1,5,0,0,1,8'hFA,8'hFF,0,0,1,1), "hij_t5");
    step(0,0,0,0,1, ex(1,6,0,0,1,8'hFB,8'hFF,1,0,0,1), "hij_t6");
    step(0,0,0,0,1, idle_pch, "hij_end");
    step(1,0,0,0,1, idle0, "hij_no_second_nmi");
    step(1,0,0,0,1, idle0, "hij_no_second_nmi2");

    // NMI edge and IRQ together: NMI first, then IRQ if I clear
    step(0,0,1,1,0, idle0, "both_pre0");
    step(0,0,1,1,0, idle0, "both_pre1");
    step(0,0,1,1,0, idle0, "both_pre2");
    step(0,0,0,0,0, idle0, "both_sync0");
    step(0,0,0,0,0, idle0, "both_sync1");
    step(0,0,0,0,0, idle0, "both_sync2");
    step(1,0,0,0,0, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0), "nmi_t1");
    step(0,0,0,0,0, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,0), "nmi_t2");
    step(0,0,0,0,0, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,0), "nmi_t3");
    step(0,0,0,0,0, ex(1,4,3,1,0,8'h00,8'h00,0,0,0,0), "nmi_t4");
    step(0,0,0,0,0, ex(1,5,0,0,1,8'hFA,8'hFF,0,0,1,0), "nmi_t5");
    step(0,0,0,0,0, ex(1,6,0,0,1,8'hFB,8'hFF,1,0,0,0), "nmi_t6");
    step(0,0,0,0,1, idle_pch, "nmi_end");
    step(1,0,0,0,1, idle0, "irq_after_nmi_masked");
    step(1,0,0,0,0, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0), "irq2_t1");
    step(0,0,0,0,0, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,0), "irq2_t2");
    step(0,0,0,0,0, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,0), "irq2_t3");
    step(0,0,0,0,0, ex(1,4,3,1,0,8'h00,8'h00,0,0,0,0), "irq2_t4");
    step(0,0,0,0,0, ex(1,5,0,0,1,8'hFE,8'hFF,0,0,1,0), "irq2_t5");
    step(0,0,0,0,0, ex(1,6,0,0,1,8'hFF,8'hFF,1,0,0,0), "irq2_t6");
    step(0,0,0,0,0, idle_pch, "irq2_end");

    // reset aborts a sequence in T3
    step(1,0,0,0,0, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0), "abt_t1");
    step(0,0,0,0,0, ex(1,2,1,1,0,8'h00,8'h00,0,0,0,0), "abt_t2");
    step(0,0,0,0,0, ex(1,3,2,1,0,8'h00,8'h00,0,0,0,0), "abt_t3");
    #2 RES_n = 1'b0;
    #1 check("abort_async", idle0);
    @(posedge phi2);
    #1 check("abort_hold", idle0);
    RES_n = 1'b1;
    step(1,0,1,1,0, ex(1,1,0,0,1,8'h00,8'h00,0,0,0,0), "res2_t1");
    step(0,0,1,1,0, ex(1,2,1,1,1,8'h00,8'h00,0,0,0,0), "res2_t2");
    step(0,0,1,1,0, ex(1,3,2,1,1,8'h00,8'h00,0,0,0,0), "res2_t3");
    step(0,0,1,1,0, ex(1,4,3,1,1,8'h00,8'h00,0,0,0,0), "res2_t4");
    step(0,0,1,1,0, ex(1,5,0,0,1,8'hFC,8'hFF,0,0,1,0), "res2_t5");
    step(0,0,1,1,0, ex(1,6,0,0,1,8'hFD,8'hFF,1,0,0,0), "res2_t6");
    step(0,0,1,1,0, idle_pch, "res2_end");
    step(1,0,1,1,0, idle0, "res2_no_repeat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL use clock/reset ports: phi2 in 1 (single clock, all state updates on posedge phi2); RES_n in 1 (asynchronous, active-low reset).
REQ-002 SHALL have input NMI_n, 1 bit: external NMI pin, asynchronous, active-low, edge-sensitive.
REQ-003 SHALL have input IRQ_n, 1 bit: external IRQ pin, asynchronous, active-low, level-sensitive.
REQ-004 SHALL have input I_flag, 1 bit: status-register I bit.
REQ-005 SHALL have input fetch_T0, 1 bit: decoder marks the opcode-fetch cycle (instruction boundary).
REQ-006 SHALL have input brk_op, 1 bit: decoded BRK; valid only with fetch_T0.
REQ-007 SHALL have output seq_active, 1 bit: sequencer owns datapath control; decoder outputs are overridden.
REQ-008 SHALL have output seq_state, 3 bits: current state encoding.
REQ-009 SHALL have output push_sel, 2 bits: DB source (0 none, 1 PCH, 2 PCL, 3 P).
REQ-010 SHALL have outputs SP_dec, 1 bit (decrement SP), and R_W_n, 1 bit (1 = read).
REQ-011 SHALL have outputs vec_ADL, 8 bits, and vec_ADH, 8 bits: vector address driven to the address bus.
REQ-012 SHALL have outputs DL_PCL and DL_PCH, 1 bit each: load the PC byte from the data latch.
REQ-013 SHALL have outputs set_I, 1 bit, and B_flag, 1 bit (B value of pushed P).

Function
REQ-014 States SHALL be IDLE, T1 (dummy read), T2 (push PCH), T3 (push PCL), T4 (push P), T5 (vector low), T6 (vector high).
REQ-015 At every fetch_T0 in IDLE, SHALL select the source by priority RESET > NMI > IRQ > BRK and go to T1 next cycle; with no source, SHALL stay in IDLE.
REQ-016 From T1 SHALL advance one state per cycle to T6, then return to IDLE; an accepted sequence SHALL last exactly 6 cycles.
REQ-017 NMI_n and IRQ_n SHALL pass through a 2-flop synchronizer; a 1->0 transition of synchronized NMI SHALL set nmi_pend.
REQ-018 nmi_pend SHALL clear in T5 of an NMI-vectored sequence; a new edge in the same cycle SHALL win (stay set).
REQ-019 IRQ SHALL be taken only if synchronized IRQ_n = 0 and I_flag = 0 at fetch_T0; there SHALL be no latching.
REQ-020 Vector SHALL be FFFC (reset), FFFA (NMI), FFFE (IRQ/BRK); vec_ADH SHALL be FF; vec_ADL SHALL be the low byte in T5 and the low byte + 1 in T6.
REQ-021 NMI hijack: if nmi_pend is set before T5 of an IRQ/BRK sequence, the vector SHALL become FFFA and nmi_pend SHALL clear; B_flag SHALL keep its original value.
REQ-022 T2/T3/T4 SHALL assert SP_dec and set push_sel to 1/2/3; R_W_n SHALL be 0 except during a reset sequence, where it SHALL stay 1.
REQ-023 B_flag SHALL be 1 only for BRK.
REQ-024 set_I SHALL pulse in T5 for all sources.
REQ-025 DL_PCL SHALL pulse in T6 (loads the T5 data); DL_PCH SHALL pulse in the first IDLE cycle after T6.
REQ-026 seq_active SHALL be 1 in T1..T6 and 0 in IDLE.
REQ-027 All outputs not named active in a state SHALL be 0; R_W_n SHALL default to 1.

Reset
REQ-028 RES_n low SHALL asynchronously force IDLE, clear nmi_pend and the synchronizers, set reset_pend, and drive all outputs to 0 except R_W_n = 1, vec_ADH = 00 and vec_ADL = 00.
REQ-029 After RES_n rises, the first fetch_T0 SHALL start the reset sequence and clear reset_pend.
REQ-030 RES_n asserted mid-sequence SHALL abort the sequence immediately, with no partial completion.

Structure
REQ-031 Shared package cpu6502_pkg SHALL hold the state enum and the vector constants VEC_NMI/VEC_RES/VEC_IRQ and the push_sel codes.
REQ-032 There SHALL be one sub-module, sync_edge_det: a 2-flop synchronizer with falling-edge pulse, instantiated for NMI_n (edge output used) and for IRQ_n (level output used).

Verification
REQ-033 Release RES_n, pulse fetch_T0 -> T1..T6 seen; SP_dec three times; R_W_n stays 1; vec_ADL FC then FD; DL_PCL then DL_PCH; set_I in T5.
REQ-034 IRQ_n low, I_flag = 0, fetch_T0 -> push_sel 1,2,3 with R_W_n = 0; B_flag = 0; vector FFFE/FFFF.
REQ-035 IRQ_n low, I_flag = 1 -> stays IDLE for 10 boundaries; brk_op at fetch_T0 -> sequence runs with B_flag = 1, vector FFFE.
REQ-036 NMI_n falls 2 cycles into a BRK sequence -> vec_ADL FA/FB; B_flag stays 1; nmi_pend clears; no second NMI sequence follows.
REQ-037 NMI_n edge and IRQ_n low at the same boundary -> NMI first (FFFA); IRQ taken at the next boundary only if I_flag is cleared.
REQ-038 RES_n low during T3 -> immediate IDLE with outputs at reset values; release plus fetch_T0 -> full reset sequence to FFFC.
